wc_tile_loader: RTL

Streaming front end for the 1-D Winograd F(6,4) core `wc`. Accepts one signed 10-bit sample per handshake and assembles overlapping 9-sample input tiles. Consecutive tiles advance by 6 samples and keep 3 samples of overlap. Each tile is presented as a 90-bit word in exactly the packing `wc` expects on its `D` port, held stable under a valid/ready handshake. The block sits between the sample source and `wc.D`.

---
 rtl/wc_pkg.sv | 25 ++
 rtl/wc_tile_loader_if.sv | 32 +++
 rtl/wc_tile_shiftreg.sv | 44 ++++
 rtl/wc_tile_loader.sv | 127 ++++++++++++
 4 files changed

// File: rtl/wc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wc_pkg
//  Description : Shared constants and FSM state type for the Winograd F(6,4)
//                tile loader front end.
//  Revision    : 1.0  initial release
// ============================================================================
package wc_pkg;

    localparam int WC_W      = 10;              // sample width
    localparam int WC_M      = 6;               // outputs per tile == stride
    localparam int WC_R      = 4;               // filter taps
    localparam int WC_T      = WC_M + WC_R - 1; // tile length (9)
    localparam int WC_OVL    = WC_R - 1;        // samples carried between tiles
    localparam int WC_TILE_W = WC_W * WC_T;
    localparam int WC_FILL_W = 4;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        HOLD = 2'd2
    } wc_state_e;

endpackage : wc_pkg
`default_nettype wire

// File: rtl/wc_tile_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : wc_tile_loader_if
//  Description : Sample-in / tile-out handshake bundle of the tile loader.
//  Revision    : 1.0  initial release
// ============================================================================
interface wc_tile_loader_if;
    import wc_pkg::*;

    logic [WC_W-1:0]      s_data;
    logic                 s_valid;
    logic                 s_last;
    logic                 s_ready;
    logic [WC_TILE_W-1:0] D;
    logic                 d_valid;
    logic                 d_last;
    logic                 d_ready;

    // Environment side: sample source and tile consumer
    modport master (
        output s_data, s_valid, s_last, d_ready,
        input  s_ready, D, d_valid, d_last
    );

    // Loader side
    modport slave (
        input  s_data, s_valid, s_last, d_ready,
        output s_ready, D, d_valid, d_last
    );

endinterface : wc_tile_loader_if
`default_nettype wire

// File: rtl/wc_tile_shiftreg.sv
`default_nettype none
// ============================================================================
//  Module      : wc_tile_shiftreg
//  Description : 9 x W tile buffer with indexed write, shift-by-stride, clear.
//  Revision    : 1.0  initial release
// ============================================================================
module wc_tile_shiftreg
    import wc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [WC_FILL_W-1:0] i_wr_idx,
    input  logic [WC_W-1:0]      i_wr_data,
    input  logic                 i_shift,
    input  logic                 i_clr,
    output logic [WC_TILE_W-1:0] o_tile
);

    logic [WC_W-1:0] r_buf [WC_T];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WC_T; i++) r_buf[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < WC_T; i++) r_buf[i] <= '0;
        end else if (i_shift) begin
            // Tail of the tile becomes the head of the next one
            for (int i = 0; i < WC_OVL; i++)    r_buf[i] <= r_buf[i+WC_M];
            for (int i = WC_OVL; i < WC_T; i++) r_buf[i] <= '0;
        end else if (i_wr_en) begin
            r_buf[i_wr_idx] <= i_wr_data;
        end
    end

    // Entry 0 (oldest) lands in the most significant slice
    generate
        for (genvar g = 0; g < WC_T; g++) begin : g_pack
            assign o_tile[WC_W*(WC_T-g)-1 -: WC_W] = r_buf[g];
        end
    endgenerate

endmodule : wc_tile_shiftreg
`default_nettype wire

// File: rtl/wc_tile_loader.sv
`default_nettype none
// ============================================================================
//  Module      : wc_tile_loader
//  Description : Assembles overlapping 9-sample tiles (stride 6) from a sample
//                stream and presents them under a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module wc_tile_loader
    import wc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    wc_tile_loader_if.slave   bus
);

    localparam logic [WC_FILL_W-1:0] c_fill_full = WC_FILL_W'(WC_T);
    localparam logic [WC_FILL_W-1:0] c_fill_ovl  = WC_FILL_W'(WC_OVL);
    localparam logic [WC_FILL_W-1:0] c_fill_one  = WC_FILL_W'(1);

    wc_state_e            r_state;
    logic [WC_FILL_W-1:0] r_fill;
    logic                 r_last_f;
    logic                 r_s_ready;
    logic                 r_d_valid;
    logic                 r_d_last;

    wc_state_e            w_state_nx;
    logic [WC_FILL_W-1:0] w_fill_nx;
    logic [WC_FILL_W-1:0] w_fill_inc;
    logic                 w_last_nx;
    logic                 w_wr_en;
    logic [WC_W-1:0]      w_wr_data;
    logic                 w_shift;
    logic                 w_clr;
    logic [WC_TILE_W-1:0] w_tile;

    assign w_fill_inc = r_fill + c_fill_one;

    always_comb begin
        w_state_nx = r_state;
        w_fill_nx  = r_fill;
        w_last_nx  = r_last_f;
        w_wr_en    = 1'b0;
        w_wr_data  = '0;
        w_shift    = 1'b0;
        w_clr      = 1'b0;
        case (r_state)
            FILL: begin
                if (bus.s_valid && r_s_ready) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = bus.s_data;
                    w_fill_nx = w_fill_inc;
                    if (w_fill_inc == c_fill_full) begin
                        w_state_nx = HOLD;
                        w_last_nx  = bus.s_last;
                    end else if (bus.s_last) begin
                        w_state_nx = PAD;
                    end
                end
            end
            PAD: begin
                w_wr_en   = 1'b1;
                w_fill_nx = w_fill_inc;
                if (w_fill_inc == c_fill_full) begin
                    w_state_nx = HOLD;
                    w_last_nx  = 1'b1;
                end
            end
            HOLD: begin
                if (bus.d_ready) begin
                    w_state_nx = FILL;
                    // A frame's final tile leaves nothing to overlap with
                    if (r_last_f) begin
                        w_clr     = 1'b1;
                        w_fill_nx = '0;
                        w_last_nx = 1'b0;
                    end else begin
                        w_shift   = 1'b1;
                        w_fill_nx = c_fill_ovl;
                    end
                end
            end
            default: begin
                w_state_nx = FILL;
                w_fill_nx  = '0;
                w_last_nx  = 1'b0;
            end
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FILL;
            r_fill    <= '0;
            r_last_f  <= 1'b0;
            r_s_ready <= 1'b0;
            r_d_valid <= 1'b0;
            r_d_last  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_fill    <= w_fill_nx;
            r_last_f  <= w_last_nx;
            r_s_ready <= (w_state_nx == FILL);
            r_d_valid <= (w_state_nx == HOLD);
            r_d_last  <= (w_state_nx == HOLD) && w_last_nx;
        end
    end

    wc_tile_shiftreg u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_fill),
        .i_wr_data (w_wr_data),
        .i_shift   (w_shift),
        .i_clr     (w_clr),
        .o_tile    (w_tile)
    );

    assign bus.s_ready = r_s_ready;
    assign bus.D       = w_tile;
    assign bus.d_valid = r_d_valid;
    assign bus.d_last  = r_d_last;

endmodule : wc_tile_loader
`default_nettype wire
